// File: rtl/logic_cfg_writer.sv
// Byte-serial configuration writer for a column of PP3 logic cells.
// Frames are checksum-validated and each cell's config word is committed atomically.
module logic_cfg_writer #(
  parameter int unsigned NCELLS   = 4,
  parameter int unsigned CFG_BITS = 16
) (
  input  logic                       QCK,
  input  logic                       QRT,
  input  logic [7:0]                 IDAT,
  input  logic                       IVLD,
  output logic                       IRDY,
  output logic [NCELLS*CFG_BITS-1:0] CFG,
  output logic                       UPD,
  output logic [7:0]                 UPD_IDX,
  output logic [NCELLS-1:0]          CELLS_OK,
  output logic                       ALL_OK,
  output logic                       ERR,
  output logic [7:0]                 ERR_CNT
);

  localparam int unsigned P    = CFG_BITS / 8;
  localparam int unsigned CntW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(P - 1);
  localparam logic [7:0] Header = 8'hA5;

  typedef enum logic [2:0] {StIdle, StIndex, StPayload, StCheck, StCommit} state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [7:0]                 idx_q, idx_d;
  logic [7:0]                 csum_q, csum_d;
  logic [CFG_BITS-1:0]        stage_q, stage_d;
  logic [NCELLS*CFG_BITS-1:0] cfg_q, cfg_d;
  logic                       upd_q, upd_d;
  logic [7:0]                 upd_idx_q, upd_idx_d;
  logic [NCELLS-1:0]          cells_ok_q, cells_ok_d;
  logic                       all_ok_q, all_ok_d;
  logic                       err_q, err_d;
  logic [7:0]                 err_cnt_q, err_cnt_d;
  logic                       irdy_q, irdy_d;
  logic                       accept;

  assign accept = IVLD && irdy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    stage_d    = stage_q;
    cfg_d      = cfg_q;
    upd_d      = 1'b0;
    upd_idx_d  = upd_idx_q;
    cells_ok_d = cells_ok_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept && IDAT == Header) begin
          state_d = StIndex;
          cnt_d   = '0;
        end
      end
      StIndex: begin
        if (accept) begin
          idx_d  = IDAT;
          csum_d = IDAT;
          cnt_d  = '0;
          if ({1'b0, IDAT} < 9'(NCELLS)) begin
            state_d = StPayload;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      StPayload: begin
        if (accept) begin
          for (int unsigned b = 0; b < P; b++) begin
            if (cnt_q == CntW'(b)) stage_d[b*8 +: 8] = IDAT;
          end
          csum_d = csum_q ^ IDAT;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_d = StCheck;
        end
      end
      StCheck: begin
        if (accept) begin
          if (IDAT == csum_q) begin
            state_d = StCommit;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      StCommit: begin
        // Only the addressed slice is touched; other cells keep their words.
        for (int unsigned k = 0; k < NCELLS; k++) begin
          if (idx_q == 8'(k)) begin
            cfg_d[k*CFG_BITS +: CFG_BITS] = stage_q;
            cells_ok_d[k]                 = 1'b1;
          end
        end
        upd_d     = 1'b1;
        upd_idx_d = idx_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    all_ok_d = &cells_ok_d;
    irdy_d   = (state_d != StCommit);
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      stage_q    <= '0;
      cfg_q      <= '0;
      upd_q      <= 1'b0;
      upd_idx_q  <= '0;
      cells_ok_q <= '0;
      all_ok_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      irdy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      stage_q    <= stage_d;
      cfg_q      <= cfg_d;
      upd_q      <= upd_d;
      upd_idx_q  <= upd_idx_d;
      cells_ok_q <= cells_ok_d;
      all_ok_q   <= all_ok_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      irdy_q     <= irdy_d;
    end
  end

  assign IRDY     = irdy_q;
  assign CFG      = cfg_q;
  assign UPD      = upd_q;
  assign UPD_IDX  = upd_idx_q;
  assign CELLS_OK = cells_ok_q;
  assign ALL_OK   = all_ok_q;
  assign ERR      = err_q;
  assign ERR_CNT  = err_cnt_q;

endmodule
